// File: rtl/fb_pkg.sv
// fb_pkg: frame-buffer geometry and scan-out constants shared with the drawing engine.
// FB_DBLBUF_EN adds a page bit to the RAM address.
package fb_pkg;
  localparam int FB_W          = 256;
  localparam int FB_H          = 192;
  localparam int WORDS_PER_ROW = 64;
  localparam int PIX_W         = 12;
  localparam int WORD_W        = 48;
  localparam int SCALE_LOG2    = 2;
  localparam int SLOT_PERIOD   = 16;
  localparam int SLOT_LEAD     = 4;
  localparam int ADDR_W        = 14;
`ifdef FB_DBLBUF_EN
  localparam int RAM_AW = ADDR_W + 1;
`else
  localparam int RAM_AW = ADDR_W;
`endif

  function automatic logic [ADDR_W-1:0] fb_word_addr(input logic [7:0] row, input logic [5:0] col);
    return {row, col};
  endfunction
endpackage

// File: rtl/fb_pix_unpack.sv
// fb_pix_unpack: two-stage fetched-word pipeline and 4x replicating pixel mux
// driving the registered RGB output.
module fb_pix_unpack
  import fb_pkg::*;
(
  input  logic              clk_65M,
  input  logic              clear_n,
  input  logic              cap,
  input  logic              load,
  input  logic              act,
  input  logic [1:0]        sel,
  input  logic [WORD_W-1:0] ram_rdata,
  output logic [PIX_W-1:0]  pix_rgb
);
  logic [WORD_W-1:0] pend_word_d, pend_word_q, act_word_d, act_word_q;
  logic [PIX_W-1:0]  pix_rgb_d, pix_rgb_q;

  always_comb begin
    pend_word_d = cap ? ram_rdata : pend_word_q;
    act_word_d  = load ? pend_word_q : act_word_q;
    pix_rgb_d   = act ? act_word_q[PIX_W*sel +: PIX_W] : '0;
  end

  always_ff @(posedge clk_65M or negedge clear_n) begin
    if (!clear_n) begin
      pend_word_q <= '0;
      act_word_q  <= '0;
      pix_rgb_q   <= '0;
    end else begin
      pend_word_q <= pend_word_d;
      act_word_q  <= act_word_d;
      pix_rgb_q   <= pix_rgb_d;
    end
  end

  assign pix_rgb = pix_rgb_q;
endmodule

// File: rtl/fb_scan_arbiter.sv
// fb_scan_arbiter: just-in-time frame-buffer fetch for 4x scaled scan-out; every other
// RAM cycle goes to the drawing port. Define FB_DBLBUF_EN for two pages swapped by page_swap.
module fb_scan_arbiter
  import fb_pkg::*;
#(
  parameter int HSTART   = 297,
  parameter int VSTART   = 36,
  parameter int FB_WORDS = 12288
) (
  input  logic              clk_65M,
  input  logic              clear_n,
  input  logic [16:0]       H_cnt,
  input  logic [16:0]       V_cnt,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  output logic              wr_gnt,
`ifdef FB_DBLBUF_EN
  input  logic              page_swap,
`endif
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  output logic [WORD_W-1:0] ram_wdata,
  input  logic [WORD_W-1:0] ram_rdata,
  output logic [PIX_W-1:0]  pix_rgb
);
  localparam int ACT_W = FB_W << SCALE_LOG2;
  localparam int ACT_H = FB_H << SCALE_LOG2;
  localparam logic [16:0] H_ACT0  = 17'(HSTART);
  localparam logic [16:0] H_ACT1  = 17'(HSTART + ACT_W);
  localparam logic [16:0] H_LEAD0 = 17'(HSTART - SLOT_LEAD);
  localparam logic [16:0] H_LEAD1 = 17'(HSTART + ACT_W - SLOT_LEAD);
  localparam logic [16:0] V_ACT0  = 17'(VSTART);
  localparam logic [16:0] V_ACT1  = 17'(VSTART + ACT_H);
  localparam logic [ADDR_W:0] WORDS_LIM = FB_WORDS[ADDR_W:0];

  logic v_act, h_act, lead, slot, cap, load;
  logic [9:0] h_off;
  logic [7:0] row;
  logic [1:0] sel;
  logic [RAM_AW-1:0] rd_addr, wr_full, ram_addr_d, ram_addr_q;
  logic ram_we_d, ram_we_q;
  logic [WORD_W-1:0] ram_wdata_d, ram_wdata_q;
`ifdef FB_DBLBUF_EN
  logic page_d, page_q;
`endif

  // h_off counts from the first slot, so its low nibble is the phase within a 16-cycle fetch period
  always_comb begin
    v_act = V_cnt >= V_ACT0 && V_cnt < V_ACT1;
    h_act = H_cnt >= H_ACT0 && H_cnt < H_ACT1;
    lead  = v_act && H_cnt >= H_LEAD0 && H_cnt < H_LEAD1;
    h_off = H_cnt[9:0] - H_LEAD0[9:0];
    slot  = lead && h_off[3:0] == 4'd0;
    cap   = lead && h_off[3:0] == 4'd2;
    load  = lead && h_off[3:0] == 4'd3;
    sel   = h_off[3:2] - 2'd1;
    row   = 8'((V_cnt[9:0] - V_ACT0[9:0]) >> SCALE_LOG2);
`ifdef FB_DBLBUF_EN
    page_d  = (H_cnt == '0 && V_cnt == '0 && page_swap) ? ~page_q : page_q;
    rd_addr = {page_q, fb_word_addr(row, h_off[9:4])};
    wr_full = {~page_q, wr_addr};
`else
    rd_addr = fb_word_addr(row, h_off[9:4]);
    wr_full = wr_addr;
`endif
    wr_gnt      = wr_req & ~slot;
    ram_addr_d  = slot ? rd_addr : wr_gnt ? wr_full : ram_addr_q;
    ram_we_d    = wr_gnt && {1'b0, wr_addr} < WORDS_LIM;
    ram_wdata_d = wr_gnt ? wr_data : ram_wdata_q;
  end

  always_ff @(posedge clk_65M or negedge clear_n) begin
    if (!clear_n) begin
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
    end else begin
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

`ifdef FB_DBLBUF_EN
  always_ff @(posedge clk_65M or negedge clear_n) begin
    if (!clear_n) page_q <= 1'b0;
    else page_q <= page_d;
  end
`endif

  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_wdata = ram_wdata_q;

  fb_pix_unpack u_unpack (
    .clk_65M   (clk_65M),
    .clear_n   (clear_n),
    .cap       (cap),
    .load      (load),
    .act       (v_act && h_act),
    .sel       (sel),
    .ram_rdata (ram_rdata),
    .pix_rgb   (pix_rgb)
  );
endmodule

// File: doc/fb_scan_arbiter.md
# fb_scan_arbiter

Frame-buffer scan-out controller and port arbiter for the 1024x768 @ 65 MHz display path. It consumes the horizontal/vertical counters from the VGA timing generator and owns the single port of a 256x192, 12-bit-per-pixel frame-buffer BRAM. It fetches pixel words just in time for scan-out with 4x4 pixel replication, and grants every remaining RAM cycle to one drawing-engine write port. It outputs the registered RGB pixel for the DAC pins.

## Interface
Parameters:
- HSTART, 297: H_cnt value of the first active pixel
- VSTART, 36: V_cnt value of the first active line
- FB_WORDS, 12288: frame-buffer depth in 48-bit words; addresses at or above this are out of range

Ports:
- clk_65M  in  1  pixel clock; the only clock
- clear_n  in  1  asynchronous, active-low reset
- H_cnt  in  17  horizontal counter from the timing generator
- V_cnt  in  17  vertical counter from the timing generator
- wr_req  in  1  drawing engine requests a write; level
- wr_addr  in  14  word address: row*64 + word
- wr_data  in  48  four pixels; pixel 0 in [11:0]
- wr_gnt  out  1  combinational; write accepted this cycle
- ram_addr  out  14 (15 with FB_DBLBUF_EN)  registered BRAM address
- ram_we  out  1  registered BRAM write enable
- ram_wdata  out  48  registered BRAM write data
- ram_rdata  in  48  BRAM read data; one-cycle synchronous read latency
- pix_rgb  out  12  registered pixel {R[3:0],G[3:0],B[3:0]}

## Operation
- Active window: HSTART ≤ H_cnt < HSTART+1024 and VSTART ≤ V_cnt < VSTART+768. Define x = H_cnt−HSTART, y = V_cnt−VSTART, fb row = y>>2, fb column = x>>2.
- Display slot: the cycle in which V_cnt is in the active window and H_cnt = HSTART+16k−4, for k = 0..63. In that cycle the next-cycle RAM access is a read of address row*64+k, with ram_we=0.
- All other cycles are writer cycles: wr_gnt = wr_req & ~display_slot. When granted, ram_addr/ram_wdata load wr_addr/wr_data. ram_we loads 1 only if wr_addr < FB_WORDS; an out-of-range write is still granted but is silently dropped.
- The writer holds wr_addr and wr_data stable until it sees wr_gnt. The display never stalls. The writer waits at most 1 cycle.
- Idle cycles (no slot, no request): ram_we=0; ram_addr holds its value.
- Data path: ram_rdata is captured into pend_word at the end of cycle H_cnt=HSTART+16k−2. pend_word is copied to act_word at the end of cycle HSTART+16k−1.
- Pixel select: during active cycle x, the selected pixel is act_word[12*((x>>2)&3) +: 12]. Outside the active window the selected value is 12'h000.

## Timing
- pix_rgb carries the pixel for counter value (H_cnt,V_cnt) one cycle later, so sync signals are delayed 1 cycle at top level.
- Read issue to data: slot cycle c, ram_addr valid c+1, ram_rdata valid c+2, act_word valid from c+4 (= first pixel of word k).
- Write: wr_gnt at cycle c, ram_we/ram_addr/ram_wdata valid during c+1.
- Reset (clear_n low, any time): ram_we=0, ram_addr=0, ram_wdata=0, pend_word=0, act_word=0, pix_rgb=0, page registers=0. wr_gnt is still combinational from wr_req and the counters. Fetching resumes correctly from the next slot after release.
- H_cnt wrap and V_cnt wrap need no special handling; the window compare is purely combinational from the counters.

## Configuration
- FB_DBLBUF_EN defined: two pages; the RAM address is {page, word}, 15 bits. Adds input page_swap (1-bit level).
  - disp_page latches ~disp_page at H_cnt=0, V_cnt=0 when page_swap=1.
  - Writes always go to ~disp_page; display reads use disp_page.
  - page_swap held across several frames toggles once per frame.
- FB_DBLBUF_EN undefined: single page, 14-bit ram_addr, no page_swap port; writes may tear.

## Structure
- Package fb_pkg holds shared constants: FB_W=256, FB_H=192, WORDS_PER_ROW=64, PIX_W=12, WORD_W=48, SCALE_LOG2=2, SLOT_PERIOD=16, SLOT_LEAD=4. The drawing engine also uses this package.
- One sub-module, fb_pix_unpack, holds pend_word, act_word, the pixel mux and the pix_rgb register. The arbiter and slot decode stay in the top module.

## Test plan
- Preload RAM word 0 = 48'hDDD_CCC_BBB_AAA; run line V_cnt=36 → pix_rgb = AAA for the 4 cycles following H_cnt 297..300, then BBB for the next 4.
- Hold wr_req=1 for a full active line → wr_gnt low at exactly the 64 slot cycles (H_cnt=293+16k), high on all others; no scan-out pixel is corrupted.
- wr_req at H_cnt=293 on an active line → wr_gnt=0 that cycle and 1 at H_cnt=294; ram_we=1 at 295.
- wr_addr=12288 granted → wr_gnt=1, ram_we stays 0, RAM unchanged.
- Assert clear_n=0 mid-line for 3 cycles → pix_rgb=0 and ram_we=0 immediately; the next line displays correctly.
- With FB_DBLBUF_EN, page_swap=1 before frame start → ram_addr[14] for reads flips at H_cnt=0, V_cnt=0; writes target the opposite page.
